lemming_array: RTL and testbench

Parametrised multi-channel Lemmings controller: N_LEM independent walker state machines share one clock and reset, each with its own sensor inputs. Each channel has a configurable fall-death threshold, an optional bounded dig duration, and a respawn input that revives a dead channel. The block is the next generation of the single-lemming controller in the behavioural-FSM benchmark set, and it reports a live-channel count alongside the per-channel status vectors.

---
 rtl/lemming_pkg.sv | 22 ++
 rtl/lemming_core.sv | 89 ++++++++
 rtl/lemming_array.sv | 56 +++++
 tb/tb_lemming_array.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lemming_pkg.sv
// Shared types for the multi-channel lemming walker: state encoding, counter width, saturating increment.
package lemming_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    WL    = 3'd0,
    WR    = 3'd1,
    FALLL = 3'd2,
    FALLR = 3'd3,
    DIGL  = 3'd4,
    DIGR  = 3'd5,
    DEAD  = 3'd6
  } lemming_state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t cnt, input cnt_t lim);
    return (cnt >= lim) ? cnt : cnt + cnt_t'(1);
  endfunction

endpackage

// File: rtl/lemming_core.sv
// One lemming channel: walk/fall/dig/dead FSM with fall and dig counters and Moore output decode.
// Latency: outputs follow the inputs sampled at the previous edge; no backpressure.
module lemming_core
  import lemming_pkg::*;
#(
  parameter int FALL_LIMIT = 20,
  parameter int DIG_MAX    = 0
) (
  input  logic clk,
  input  logic areset_n,
  input  logic i_bump_left,
  input  logic i_bump_right,
  input  logic i_ground,
  input  logic i_dig,
  input  logic i_respawn,
  output logic o_walk_left,
  output logic o_walk_right,
  output logic o_aaah,
  output logic o_digging,
  output logic o_dead
);

  localparam cnt_t FALL_LIM    = cnt_t'(FALL_LIMIT);
  localparam cnt_t DIG_LAST    = cnt_t'(DIG_MAX - 1);
  localparam bit   DIG_BOUNDED = (DIG_MAX != 0);

  lemming_state_t r_state;
  lemming_state_t w_state_nxt;
  cnt_t           r_fall_cnt;
  cnt_t           r_dig_cnt;
  logic           w_falling;
  logic           w_digging;
  logic           w_fall_fatal;
  logic           w_dig_done;

  assign w_falling    = (r_state == FALLL) || (r_state == FALLR);
  assign w_digging    = (r_state == DIGL)  || (r_state == DIGR);
  assign w_fall_fatal = (r_fall_cnt >= FALL_LIM);
  assign w_dig_done   = DIG_BOUNDED && (r_dig_cnt == DIG_LAST);

  // Priority inside walk states: ground loss, then dig, then bump.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WL: begin
        if (!i_ground)        w_state_nxt = FALLL;
        else if (i_dig)       w_state_nxt = DIGL;
        else if (i_bump_left) w_state_nxt = WR;
      end
      WR: begin
        if (!i_ground)         w_state_nxt = FALLR;
        else if (i_dig)        w_state_nxt = DIGR;
        else if (i_bump_right) w_state_nxt = WL;
      end
      FALLL: if (i_ground) w_state_nxt = w_fall_fatal ? DEAD : WL;
      FALLR: if (i_ground) w_state_nxt = w_fall_fatal ? DEAD : WR;
      DIGL: begin
        if (!i_ground)       w_state_nxt = FALLL;
        else if (w_dig_done) w_state_nxt = WL;
      end
      DIGR: begin
        if (!i_ground)       w_state_nxt = FALLR;
        else if (w_dig_done) w_state_nxt = WR;
      end
      DEAD:    if (i_respawn) w_state_nxt = WL;
      default: w_state_nxt = WL;
    endcase
  end

  // Counters track the current state, so they read zero on the first cycle of a fall or dig.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state    <= WL;
      r_fall_cnt <= '0;
      r_dig_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fall_cnt <= w_falling ? sat_inc(r_fall_cnt, FALL_LIM) : '0;
      r_dig_cnt  <= w_digging ? sat_inc(r_dig_cnt, {CNT_W{1'b1}}) : '0;
    end
  end

  assign o_walk_left  = (r_state == WL);
  assign o_walk_right = (r_state == WR);
  assign o_aaah       = w_falling;
  assign o_digging    = w_digging;
  assign o_dead       = (r_state == DEAD);

endmodule

// File: rtl/lemming_array.sv
// N_LEM independent lemming channels plus a live-channel count decoded from the dead vector.
// Latency: one cycle from input sample to status; alive_count is combinational from state; no backpressure.
module lemming_array #(
  parameter int N_LEM      = 4,
  parameter int FALL_LIMIT = 20,
  parameter int DIG_MAX    = 0
) (
  input  logic                         clk,
  input  logic                         areset_n,
  input  logic [N_LEM-1:0]             bump_left,
  input  logic [N_LEM-1:0]             bump_right,
  input  logic [N_LEM-1:0]             ground,
  input  logic [N_LEM-1:0]             dig,
  input  logic [N_LEM-1:0]             respawn,
  output logic [N_LEM-1:0]             walk_left,
  output logic [N_LEM-1:0]             walk_right,
  output logic [N_LEM-1:0]             aaah,
  output logic [N_LEM-1:0]             digging,
  output logic [N_LEM-1:0]             dead,
  output logic [$clog2(N_LEM+1)-1:0]   alive_count
);

  localparam int AW = $clog2(N_LEM + 1);

  logic [AW-1:0] w_dead_cnt;

  for (genvar g = 0; g < N_LEM; g++) begin : g_lem
    lemming_core #(
      .FALL_LIMIT (FALL_LIMIT),
      .DIG_MAX    (DIG_MAX)
    ) u_core (
      .clk          (clk),
      .areset_n     (areset_n),
      .i_bump_left  (bump_left[g]),
      .i_bump_right (bump_right[g]),
      .i_ground     (ground[g]),
      .i_dig        (dig[g]),
      .i_respawn    (respawn[g]),
      .o_walk_left  (walk_left[g]),
      .o_walk_right (walk_right[g]),
      .o_aaah       (aaah[g]),
      .o_digging    (digging[g]),
      .o_dead       (dead[g])
    );
  end

  always_comb begin
    w_dead_cnt = '0;
    for (int i = 0; i < N_LEM; i++) begin
      w_dead_cnt = w_dead_cnt + AW'(dead[i]);
    end
  end

  assign alive_count = AW'(N_LEM) - w_dead_cnt;

endmodule

// File: tb/tb_lemming_array.sv
// Directed and randomised checks of lemming_array with unbounded (DIG_MAX=0) and bounded (DIG_MAX=5) dig.
module tb_lemming_array;

  logic       clk = 1'b0;
  logic       areset_n;
  logic [3:0] bump_left, bump_right, ground, dig, respawn;
  logic [3:0] wl0, wr0, aa0, dg0, dd0;
  logic [3:0] wl5, wr5, aa5, dg5, dd5;
  logic [2:0] al0, al5;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 walk, 1 fall, 2 dig, 3 dead; dir 0 left, 1 right. Counters never wrap.
  int m_mode [2][4];
  bit m_dir  [2][4];
  int m_fc   [2][4];
  int m_dc   [2][4];
  int gl_left[4];

  always #5 clk = ~clk;

  lemming_array #(.N_LEM(4), .FALL_LIMIT(20), .DIG_MAX(0)) u_dut0 (
    .clk(clk), .areset_n(areset_n),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground), .dig(dig), .respawn(respawn),
    .walk_left(wl0), .walk_right(wr0), .aaah(aa0), .digging(dg0), .dead(dd0), .alive_count(al0)
  );

  lemming_array #(.N_LEM(4), .FALL_LIMIT(20), .DIG_MAX(5)) u_dut5 (
    .clk(clk), .areset_n(areset_n),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground), .dig(dig), .respawn(respawn),
    .walk_left(wl5), .walk_right(wr5), .aaah(aa5), .digging(dg5), .dead(dd5), .alive_count(al5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        m_mode[d][c] = 0; m_dir[d][c] = 1'b0; m_fc[d][c] = 0; m_dc[d][c] = 0;
      end
  endtask

  task automatic model_step();
    int dm;
    for (int d = 0; d < 2; d++) begin
      dm = (d == 0) ? 0 : 5;
      for (int c = 0; c < 4; c++) begin
        case (m_mode[d][c])
          0: begin
            if (!ground[c]) begin m_mode[d][c] = 1; m_fc[d][c] = 0; end
            else if (dig[c]) begin m_mode[d][c] = 2; m_dc[d][c] = 0; end
            else if (m_dir[d][c] ? bump_right[c] : bump_left[c]) m_dir[d][c] = ~m_dir[d][c];
          end
          1: begin
            if (!ground[c]) m_fc[d][c]++;
            else m_mode[d][c] = (m_fc[d][c] >= 20) ? 3 : 0;
          end
          2: begin
            if (!ground[c]) begin m_mode[d][c] = 1; m_fc[d][c] = 0; end
            else if (dm != 0 && m_dc[d][c] == dm - 1) m_mode[d][c] = 0;
            else m_dc[d][c]++;
          end
          default: if (respawn[c]) begin m_mode[d][c] = 0; m_dir[d][c] = 1'b0; end
        endcase
      end
    end
  endtask

  function automatic logic [22:0] model_vec(input int d);
    logic [3:0] wl, wr, aa, dg, dd;
    int alive;
    alive = 4;
    for (int c = 0; c < 4; c++) begin
      wl[c] = (m_mode[d][c] == 0) && !m_dir[d][c];
      wr[c] = (m_mode[d][c] == 0) &&  m_dir[d][c];
      aa[c] = (m_mode[d][c] == 1);
      dg[c] = (m_mode[d][c] == 2);
      dd[c] = (m_mode[d][c] == 3);
      if (dd[c]) alive--;
    end
    return {wl, wr, aa, dg, dd, 3'(alive)};
  endfunction

  initial begin
    areset_n = 1'b0;
    ground = 4'hF; dig = 4'h0; bump_left = 4'h0; bump_right = 4'h0; respawn = 4'h0;
    #3;
    check("rst_wl",    32'(wl0), 32'hF);
    check("rst_wr",    32'(wr0), 32'h0);
    check("rst_aaah",  32'(aa0), 32'h0);
    check("rst_dig",   32'(dg0), 32'h0);
    check("rst_dead",  32'(dd0), 32'h0);
    check("rst_alive", 32'(al0), 32'd4);
    check("rst_wl5",   32'(wl5), 32'hF);
    step();
    areset_n = 1'b1;

    // Priority: ground loss beats dig beats bump
    bump_left = 4'b0010; step();
    check("pri_setup_wr", 32'(wr0), 32'b0010);
    ground = 4'b1110; dig = 4'b0011; bump_left = 4'b0001; bump_right = 4'b0010; step();
    check("pri_fall", 32'(aa0), 32'b0001);
    check("pri_dig",  32'(dg0), 32'b0010);
    check("pri_wl",   32'(wl0), 32'b1100);
    dig = 4'h0; bump_left = 4'h0; bump_right = 4'h0; step(); step();
    check("mid_fall", 32'(aa0), 32'b0001);
    check("mid_dig",  32'(dg0), 32'b0010);

    // Asynchronous reset aborts fall and dig at once
    #2 areset_n = 1'b0;
    #1;
    check("arst_wl",    32'(wl0), 32'hF);
    check("arst_wr",    32'(wr0), 32'h0);
    check("arst_aaah",  32'(aa0), 32'h0);
    check("arst_dig",   32'(dg0), 32'h0);
    check("arst_alive", 32'(al0), 32'd4);
    ground = 4'hF;
    #2 areset_n = 1'b1;
    step();
    check("post_rst_wl", 32'(wl0), 32'hF);

    // Fall boundary: 20 low cycles survive, 21 kill
    ground = 4'b1100;
    repeat (20) step();
    check("fb_falling", 32'(aa0), 32'b0011);
    ground = 4'b1101; step();
    check("fb_land20_wl", 32'(wl0), 32'b1101);
    check("fb_land20_aa", 32'(aa0), 32'b0010);
    ground = 4'hF; step();
    check("fb_dead21",  32'(dd0), 32'b0010);
    check("fb_alive",   32'(al0), 32'd3);
    check("fb_wl",      32'(wl0), 32'b1101);

    // Long falls: counter must saturate, not wrap (257 and 300 cycles)
    ground = 4'b0011;
    repeat (257) step();
    check("sat_falling", 32'(aa0), 32'b1100);
    ground = 4'b0111; step();
    check("sat_dead257", 32'(dd0), 32'b0110);
    check("sat_alive2",  32'(al0), 32'd2);
    repeat (42) step();
    check("sat_still_fall", 32'(aa0), 32'b1000);
    ground = 4'hF; step();
    check("sat_dead300", 32'(dd0), 32'b1110);
    check("sat_alive1",  32'(al0), 32'd1);

    // Respawn revives DEAD only; ignored in WR
    bump_left = 4'b0001; step();
    check("rsp_setup_wr", 32'(wr0), 32'b0001);
    bump_left = 4'h0; respawn = 4'b0101; step();
    check("rsp_wl",    32'(wl0), 32'b0100);
    check("rsp_wr",    32'(wr0), 32'b0001);
    check("rsp_dead",  32'(dd0), 32'b1010);
    check("rsp_alive", 32'(al0), 32'd2);
    respawn = 4'b1010; step();
    check("rsp_all_wl",    32'(wl0), 32'b1110);
    check("rsp_all_alive", 32'(al0), 32'd4);
    respawn = 4'h0;

    // Bounded dig, DIG_MAX=5
    areset_n = 1'b0; #1 areset_n = 1'b1;
    bump_left = 4'b0001; step();
    check("bd_setup_wr", 32'(wr5), 32'b0001);
    bump_left = 4'h0; dig = 4'b0001; step();
    check("bd_dig_c1", 32'(dg5), 32'b0001);
    dig = 4'h0;
    for (int k = 2; k <= 5; k++) begin
      step();
      check("bd_dig_cn", 32'(dg5), 32'b0001);
    end
    step();
    check("bd_end_dig", 32'(dg5), 32'b0000);
    check("bd_end_wr",  32'(wr5), 32'b0001);
    check("bd_unbounded", 32'(dg0), 32'b0001);
    dig = 4'b0001; step();
    check("bd2_dig_c1", 32'(dg5), 32'b0001);
    dig = 4'h0;
    repeat (4) step();
    ground = 4'b1110; step();
    check("bd2_fall",    32'(aa5), 32'b0001);
    check("bd2_not_dig", 32'(dg5), 32'b0000);
    check("bd2_fall_d0", 32'(aa0), 32'b0001);
    ground = 4'hF; step();
    check("bd2_land_wr",    32'(wr5), 32'b0001);
    check("bd2_land_wr_d0", 32'(wr0), 32'b0001);

    // Randomised independence run against the model
    areset_n = 1'b0; #1 areset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) gl_left[c] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if (gl_left[c] > 0) begin
          ground[c] = 1'b0; gl_left[c]--;
        end else if ($urandom_range(0, 15) == 0) begin
          ground[c] = 1'b0; gl_left[c] = int'($urandom_range(0, 39));
        end else begin
          ground[c] = 1'b1;
        end
        dig[c]        = ($urandom_range(0, 7) == 0);
        bump_left[c]  = ($urandom_range(0, 3) == 0);
        bump_right[c] = ($urandom_range(0, 3) == 0);
        respawn[c]    = ($urandom_range(0, 7) == 0);
      end
      @(posedge clk);
      model_step();
      #1;
      check("rnd_dig0", 32'({wl0, wr0, aa0, dg0, dd0, al0}), 32'(model_vec(0)));
      check("rnd_dig5", 32'({wl5, wr5, aa5, dg5, dd5, al5}), 32'(model_vec(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
